// File: rtl/dac_upd_ctrl.sv
// ============================================================================
// Module  : dac_upd_ctrl
// Brief   : Round-robin sample arbiter, per-channel shadow buffers, prescaled
//           update ticks and delayed latch strobe for a 4-channel 8-bit DAC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_upd_ctrl #(
   parameter int DW    = 8,
   parameter int DIV_W = 16
) (
   input  logic               mclk,
   input  logic               reset,
   input  logic               cfg_en,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic [3:0]         req_valid,
   input  logic [4*DW-1:0]    req_data,
   output logic [3:0]         req_ready,
   output logic [DW-1:0]      dac_din0,
   output logic [DW-1:0]      dac_din1,
   output logic [DW-1:0]      dac_din2,
   output logic [DW-1:0]      dac_din3,
   output logic               dac_load,
   output logic [3:0]         underrun,
   input  logic [3:0]         underrun_clr
);

   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

   logic [DW-1:0]    shadow [4];
   logic [DW-1:0]    din_q  [4];
   logic [3:0]       pending;
   logic [1:0]       ptr;
   logic [DIV_W-1:0] count;
   logic             tick_d1;

   logic [3:0]       grant;
   logic [1:0]       grant_idx;
   logic             grant_any;
   logic [1:0]       scan_idx;
   logic [DIV_W-1:0] eff_div;
   logic             tick;
   logic [3:0]       xfer;

   // First eligible channel in rotation order starting at ptr.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr + 2'(k);
         if (!grant_any && req_valid[scan_idx] && !pending[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
            grant_any       = 1'b1;
         end
      end
   end

   assign req_ready = reset ? 4'b0000 : grant;
   assign xfer      = req_ready & req_valid;

   // The >= compare lets a lowered divisor fire at once instead of wrapping.
   assign eff_div = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
   assign tick    = cfg_en && (count >= eff_div);

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         ptr      <= '0;
         tick_d1  <= 1'b0;
         dac_load <= 1'b0;
      end else begin
         if (!cfg_en || tick) begin
            count <= '0;
         end else begin
            count <= count + DIV_W'(1);
         end
         if (|xfer) begin
            ptr <= grant_idx + 2'd1;
         end
         tick_d1  <= tick;
         dac_load <= tick_d1;
      end
   end

   // A tick sees pre-transfer state, so a same-cycle write stays pending.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         underrun <= '0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= '0;
            din_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (underrun_clr[i]) begin
               underrun[i] <= 1'b0;
            end
            if (tick) begin
               if (pending[i]) begin
                  din_q[i] <= shadow[i];
               end else begin
                  underrun[i] <= 1'b1;
               end
            end
            if (xfer[i]) begin
               shadow[i]  <= req_data[DW*i +: DW];
               pending[i] <= 1'b1;
            end else if (tick) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   assign dac_din0 = din_q[0];
   assign dac_din1 = din_q[1];
   assign dac_din2 = din_q[2];
   assign dac_din3 = din_q[3];

endmodule

`default_nettype wire

// File: tb/tb_dac_upd_ctrl.sv
// ============================================================================
// Module  : tb_dac_upd_ctrl
// Brief   : Directed plus randomized bench for dac_upd_ctrl against a
//           transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dac_upd_ctrl;

   logic        mclk;
   logic        reset;
   logic        cfg_en;
   logic [15:0] cfg_div;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  dac_din0, dac_din1, dac_din2, dac_din3;
   logic        dac_load;
   logic [3:0]  underrun;
   logic [3:0]  underrun_clr;

   dac_upd_ctrl #(.DW(8), .DIV_W(16)) dut (
      .mclk         (mclk),
      .reset        (reset),
      .cfg_en       (cfg_en),
      .cfg_div      (cfg_div),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .dac_din0     (dac_din0),
      .dac_din1     (dac_din1),
      .dac_din2     (dac_din2),
      .dac_din3     (dac_din3),
      .dac_load     (dac_load),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: what is waiting, what the DAC shows, and when strobes are due.
   bit [3:0]   m_pend;
   bit [3:0]   m_under;
   logic [7:0] m_shadow [4];
   logic [7:0] m_din    [4];
   int         m_ptr;
   int         m_since;
   int         load_due [$];
   int         cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_under = '0;
      m_ptr   = 0;
      m_since = 0;
      load_due.delete();
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = '0;
         m_din[i]    = '0;
      end
   endtask

   function automatic int exp_grant();
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (m_ptr + k) % 4;
         if (req_valid[c] && !m_pend[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit model_tick();
      int eff;
      eff = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
      return cfg_en && (m_since >= eff);
   endfunction

   task automatic model_update(input int g);
      bit t;
      t = model_tick();
      for (int i = 0; i < 4; i++) if (underrun_clr[i]) m_under[i] = 1'b0;
      if (t) begin
         load_due.push_back(cyc + 2);
         for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) begin
               m_din[i]  = m_shadow[i];
               m_pend[i] = 1'b0;
            end else begin
               m_under[i] = 1'b1;
            end
         end
      end
      if (g >= 0) begin
         m_shadow[g] = req_data[8*g +: 8];
         m_pend[g]   = 1'b1;
         m_ptr       = (g + 1) % 4;
      end
      m_since = (!cfg_en || t) ? 0 : m_since + 1;
   endtask

   // Called at posedge+1 with inputs already driven; returns at next posedge+1.
   task automatic step();
      int         g;
      logic [3:0] exp_ready;
      bit         exp_load;
      #1;
      if (reset) model_reset();
      g         = exp_grant();
      exp_ready = (reset || g < 0) ? 4'b0000 : (4'b0001 << g);
      while (load_due.size() > 0 && load_due[0] < cyc) void'(load_due.pop_front());
      exp_load  = (load_due.size() > 0) && (load_due[0] == cyc);
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      chk("dac_load", {31'd0, dac_load}, {31'd0, exp_load});
      chk("dac_din", {dac_din3, dac_din2, dac_din1, dac_din0},
          {m_din[3], m_din[2], m_din[1], m_din[0]});
      chk("underrun", {28'd0, underrun}, {28'd0, m_under});
      @(posedge mclk);
      if (reset) model_reset();
      else model_update(g);
      cyc++;
      #1;
   endtask

   initial begin
      bit found;
      reset        = 1'b1;
      cfg_en       = 1'b0;
      cfg_div      = 16'd0;
      req_valid    = 4'hF;
      req_data     = 32'hDEADBEEF;
      underrun_clr = 4'h0;
      model_reset();
      @(posedge mclk);
      #1;

      // Reset state, with requests present to show req_ready held low.
      step();
      reset     = 1'b0;
      req_valid = 4'h0;
      step();

      // Single channel-0 write, period 5.
      cfg_en    = 1'b1;
      cfg_div   = 16'd4;
      req_valid = 4'b0001;
      req_data  = 32'h0000_00A5;
      step();
      req_valid = 4'h0;
      repeat (6) step();
      chk("t1_din0", {24'd0, dac_din0}, 32'h0000_00A5);

      // All four channels requesting from pointer 0.
      reset = 1'b1;
      step();
      reset     = 1'b0;
      cfg_div   = 16'd6;
      req_valid = 4'hF;
      req_data  = 32'h4433_2211;
      repeat (7) step();
      req_valid = 4'h0;
      repeat (2) step();
      chk("t2_dins", {dac_din3, dac_din2, dac_din1, dac_din0}, 32'h4433_2211);

      // Divisor below minimum: period 3.
      cfg_div = 16'd0;
      repeat (12) step();
      chk("t3_under2", {31'd0, underrun[2]}, 32'd1);
      chk("t3_din2", {24'd0, dac_din2}, 32'h0000_0033);

      // Underrun clear, then clear colliding with a new underrun.
      cfg_en       = 1'b0;
      underrun_clr = 4'hF;
      step();
      underrun_clr = 4'h0;
      chk("t4_cleared", {28'd0, underrun}, 32'd0);
      cfg_en  = 1'b1;
      cfg_div = 16'd2;
      repeat (2) step();
      underrun_clr = 4'b0100;
      step();
      underrun_clr = 4'h0;
      chk("t4_set_wins", {31'd0, underrun[2]}, 32'd1);

      // Channel-1 write landing on the tick cycle.
      cfg_en       = 1'b0;
      underrun_clr = 4'hF;
      step();
      underrun_clr = 4'h0;
      cfg_en       = 1'b1;
      repeat (2) step();
      req_valid = 4'b0010;
      req_data  = 32'h0000_5A00;
      step();
      req_valid = 4'h0;
      chk("t5_din1_hold", {24'd0, dac_din1}, 32'h0000_0022);
      chk("t5_under1", {31'd0, underrun[1]}, 32'd1);
      repeat (3) step();
      chk("t5_din1_new", {24'd0, dac_din1}, 32'h0000_005A);

      // Randomized traffic and configuration churn.
      for (int n = 0; n < 400; n++) begin
         req_valid = 4'($urandom_range(0, 15));
         req_data  = $urandom();
         if ($urandom_range(0, 15) == 0) cfg_div = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 19) == 0) cfg_en = ~cfg_en;
         underrun_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         step();
      end

      // Reset with pending data and a strobe in flight.
      cfg_en       = 1'b1;
      cfg_div      = 16'd3;
      underrun_clr = 4'h0;
      req_valid    = 4'b1000;
      req_data     = 32'h7700_0000;
      step();
      req_valid = 4'h0;
      found     = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (model_tick()) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("t6_tick_found", {31'd0, found}, 32'd1);
      req_valid = 4'hF;
      req_data  = $urandom();
      step();
      req_valid = 4'h0;
      reset     = 1'b1;
      step();
      step();
      chk("t6_no_load", {31'd0, dac_load}, 32'd0);
      reset = 1'b0;
      repeat (5) step();
      chk("t6_first_load", {31'd0, dac_load}, 32'd1);
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
